keypad_emulator: RTL and testbench
==================================

# keypad_emulator

Drives the row lines of a 4x4 PmodKYPD-style keypad in response to the column strobes from the calculator's keypad scan decoder, so the calculator can run without the physical keypad. A host such as switch logic, a UART command parser or a testbench queues 4-bit key codes into an internal FIFO. The block then replays each code as a timed press followed by a release gap. It sits on the JC row/column nets in place of the Pmod.

## Interface
Parameters:
- HOLD_CYCLES, 2_000_000, clock cycles a key is held pressed (20 ms at 100 MHz); must be ≥ 1.
- GAP_CYCLES, 2_000_000, clock cycles of release after each press; must be ≥ 1.
- FIFO_DEPTH, 8, key-code FIFO entries; must be a power of 2, ≥ 2.

Ports:
- clk  in  1  100 MHz system clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- key_in  in  4  key code to queue (0x0–0xF, PmodKYPD legend).
- key_valid  in  1  push request for key_in.
- key_ready  out  1  FIFO not full; a push happens on a cycle with key_valid & key_ready.
- col_in  in  4  column strobes from the scan decoder, active-low; bit 3 is the first column.
- row_out  out  4  emulated row lines, active-low, registered; bit 3 is the first row.
- pressed  out  1  a key is currently being held.
- key_active  out  4  code of the held or last-held key.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of queued entries.

## Operation
- Key map (column bit, row bit):
  - col bit 3: 1,4,7,0
  - col bit 2: 2,5,8,F
  - col bit 1: 3,6,9,E
  - col bit 0: A,B,C,D
  - rows: bit3 = {1,2,3,A}, bit2 = {4,5,6,B}, bit1 = {7,8,9,C}, bit0 = {0,F,E,D}
- FIFO:
  - Circular buffer with separate read/write pointers and a count register.
  - key_ready = (fifo_count != FIFO_DEPTH) and depends on state only, never on key_valid.
  - A push while full is dropped, even if a pop happens in the same cycle.
  - A simultaneous push and pop when not full leaves fifo_count unchanged.
- FSM states IDLE, PRESS, GAP:
  - IDLE: if fifo_count ≠ 0, pop the head into key_active, load cnt = HOLD_CYCLES-1, set pressed=1, go to PRESS.
  - PRESS: if cnt = 0, set pressed=0, load cnt = GAP_CYCLES-1, go to GAP; else decrement cnt.
  - GAP: if cnt = 0, go to IDLE; else decrement cnt.
- Row drive, registered, updated every clock:
  - row_out ← ~(1<<r) when pressed=1 and col_in[c]=0, where (c, r) is the map position of key_active.
  - Otherwise row_out ← 4'b1111.
  - Other columns being low at the same time does not matter; only bit c is checked.
- busy = (fifo_count ≠ 0) | (state ≠ IDLE).
- Reset values: row_out=4'b1111, pressed=0, key_active=0, busy=0, fifo_count=0, key_ready=1, state=IDLE, pointers=0.
- Reset asserted mid-press aborts the press and discards queued keys. All outputs reach their reset values at the first clock edge with reset_n=0.

## Timing
- Push at edge t:
  - fifo_count increments after edge t.
  - If the FSM is in IDLE, the pop happens at edge t+1; pressed and key_active are valid after t+1.
- The pop at edge t+1 decrements fifo_count after that edge.
- pressed stays high for exactly HOLD_CYCLES cycles, then low for at least GAP_CYCLES cycles.
- Back-to-back queued keys give a press period of HOLD_CYCLES + GAP_CYCLES + 1 cycles; the extra cycle is the IDLE pop.
- row_out lags col_in and pressed by one cycle. The scan decoder's settle time between driving a column and sampling the rows is far longer than one cycle.
- Counters are at least $clog2(max(HOLD_CYCLES, GAP_CYCLES)) bits wide and never wrap.

## Test plan
Run with HOLD_CYCLES=8, GAP_CYCLES=4, FIFO_DEPTH=4.

- After reset, col_in cycles through 0111/1011/1101/1110 with no push:
  - row_out stays 1111.
  - busy=0, key_ready=1, fifo_count=0.
- Push 0x5, hold col_in=1011:
  - pressed rises 1 cycle after the push and lasts 8 cycles.
  - row_out=1011 for those 8 cycles, one cycle delayed.
  - col_in=0111 during the press gives row_out=1111.
- Push 0x1, 0x2, 0x0xA, 0xD back to back, i.e. 0x1, 0x2, 0xA, 0xD, with col_in sweeping continuously:
  - The keys replay in order with pressed periods 13 cycles apart.
  - The decoded (col, row) pairs are (0111,0111), (1011,0111), (1110,0111), (1110,1110).
- Fill the FIFO (4 pushes while PRESS is blocked) and push 0xF:
  - key_ready=0 and 0xF is dropped.
  - fifo_count stays 4.
- When full, drive key_valid in the same cycle the IDLE pop occurs:
  - The push is rejected.
  - fifo_count goes 4→3.
- Assert reset_n=0 for 1 cycle in the middle of a PRESS with 2 keys queued:
  - After the edge: row_out=1111, pressed=0, fifo_count=0, busy=0.
  - No further presses occur.

Source files
------------

// File: rtl/keypad_emulator.sv
// Keypad emulator: queues 4-bit key codes and replays each one as a timed press
// and release gap on active-low row lines, answering the scan decoder's column strobes.
//
// state | meaning
// IDLE  | waiting for a queued key; pops the FIFO head when one is present
// PRESS | key held, row line answers its column strobe; counts down the hold time
// GAP   | key released; counts down the release gap before the next key
module keypad_emulator #(
  parameter int HOLD_CYCLES = 2_000_000,
  parameter int GAP_CYCLES  = 2_000_000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [3:0]                    key_in,
  input  logic                          key_valid,
  output logic                          key_ready,
  input  logic [3:0]                    col_in,
  output logic [3:0]                    row_out,
  output logic                          pressed,
  output logic [3:0]                    key_active,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0]   HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]   GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [CNTW-1:0] DEPTH_L   = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            pressed_nxt;
  logic [3:0]      key_nxt;
  logic            pop;
  logic            push;

  logic [3:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [3:0]      head;

  logic [1:0]      sel_c;
  logic [1:0]      sel_r;

  // Ready is a function of the stored count only, so a push while full is
  // dropped even when the FSM pops in the same cycle.
  assign key_ready = (fifo_count != DEPTH_L);
  assign push      = key_valid & key_ready;
  assign head      = mem[rd_ptr];
  assign busy      = (fifo_count != '0) | (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= key_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pressed    <= 1'b0;
      key_active <= 4'h0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pressed    <= pressed_nxt;
      key_active <= key_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pressed_nxt = pressed;
    key_nxt     = key_active;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop         = 1'b1;
          key_nxt     = head;
          cnt_nxt     = HOLD_LOAD;
          pressed_nxt = 1'b1;
          state_nxt   = PRESS;
        end
      end
      PRESS: begin
        if (cnt == '0) begin
          pressed_nxt = 1'b0;
          cnt_nxt     = GAP_LOAD;
          state_nxt   = GAP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        pressed_nxt = 1'b0;
        state_nxt   = IDLE;
      end
    endcase
  end

  // Column/row bit position of each key on the PmodKYPD legend.
  always_comb begin
    sel_c = 2'd3;
    sel_r = 2'd3;
    case (key_active)
      4'h1: begin sel_c = 2'd3; sel_r = 2'd3; end
      4'h4: begin sel_c = 2'd3; sel_r = 2'd2; end
      4'h7: begin sel_c = 2'd3; sel_r = 2'd1; end
      4'h0: begin sel_c = 2'd3; sel_r = 2'd0; end
      4'h2: begin sel_c = 2'd2; sel_r = 2'd3; end
      4'h5: begin sel_c = 2'd2; sel_r = 2'd2; end
      4'h8: begin sel_c = 2'd2; sel_r = 2'd1; end
      4'hF: begin sel_c = 2'd2; sel_r = 2'd0; end
      4'h3: begin sel_c = 2'd1; sel_r = 2'd3; end
      4'h6: begin sel_c = 2'd1; sel_r = 2'd2; end
      4'h9: begin sel_c = 2'd1; sel_r = 2'd1; end
      4'hE: begin sel_c = 2'd1; sel_r = 2'd0; end
      4'hA: begin sel_c = 2'd0; sel_r = 2'd3; end
      4'hB: begin sel_c = 2'd0; sel_r = 2'd2; end
      4'hC: begin sel_c = 2'd0; sel_r = 2'd1; end
      4'hD: begin sel_c = 2'd0; sel_r = 2'd0; end
      default: begin sel_c = 2'd3; sel_r = 2'd3; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      row_out <= 4'b1111;
    end else if (pressed && !col_in[sel_c]) begin
      row_out <= ~(4'b0001 << sel_r);
    end else begin
      row_out <= 4'b1111;
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: stimulus queues expected presses into a
// scoreboard, a negedge monitor checks each press, its rows, length and spacing.
module tb_keypad_emulator;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] key_in;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic       pressed;
  logic [3:0] key_active;
  logic       busy;
  logic [2:0] fifo_count;

  keypad_emulator #(.HOLD_CYCLES(8), .GAP_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .col_in     (col_in),
    .row_out    (row_out),
    .pressed    (pressed),
    .key_active (key_active),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] key;
    logic [3:0] col;
    logic [3:0] row;
    int         period;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic       mon_en   = 1'b0;
  logic       col_mode = 1'b1;
  logic [3:0] col_fixed = 4'b1111;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Column strobe driver: sweeps one low column per cycle or holds a fixed value.
  initial begin
    int idx;
    idx = 0;
    col_in = 4'b1111;
    forever begin
      @(posedge clk);
      #1;
      if (col_mode) begin
        case (idx % 4)
          0: col_in = 4'b0111;
          1: col_in = 4'b1011;
          2: col_in = 4'b1101;
          default: col_in = 4'b1110;
        endcase
        idx++;
      end else begin
        col_in = col_fixed;
      end
    end
  end

  // Monitor: row_out at a negedge answers pressed/col_in sampled one negedge earlier.
  initial begin
    logic       prev_pressed;
    logic [3:0] prev_col;
    logic [3:0] exp_r;
    exp_t       cur;
    logic       cur_valid;
    int         cyc;
    int         last_rise;
    int         hold_len;
    prev_pressed = 1'b0;
    prev_col     = 4'b1111;
    cur_valid    = 1'b0;
    cyc          = 0;
    last_rise    = 0;
    hold_len     = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        exp_r = 4'b1111;
        if (prev_pressed && cur_valid && prev_col == cur.col) exp_r = cur.row;
        chk("row_out", 32'(row_out), 32'(exp_r));
        if (pressed && !prev_pressed) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_press: got key %0h expected no press at %0t", key_active, $time);
            cur_valid = 1'b0;
          end else begin
            cur = sb.pop_front();
            cur_valid = 1'b1;
            chk("key_active", 32'(key_active), 32'(cur.key));
            if (cur.period != 0) chk("press_period", 32'(cyc - last_rise), 32'(cur.period));
          end
          last_rise = cyc;
          hold_len  = 1;
        end else if (pressed) begin
          hold_len++;
        end else if (prev_pressed && cur_valid) begin
          chk("press_length", 32'(hold_len), 32'd8);
        end
      end
      prev_pressed = pressed;
      prev_col     = col_in;
    end
  end

  task automatic push(input logic [3:0] k);
    key_in    = k;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic expect_key(input logic [3:0] k, input logic [3:0] c, input logic [3:0] r,
                            input int period);
    exp_t e;
    e.key = k; e.col = c; e.row = r; e.period = period;
    sb.push_back(e);
    push(k);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((busy || pressed) && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy || pressed) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=%0b expected busy=0 after %0d cycles", busy, bound);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int   waited;
    logic saw_press;
    reset_n   = 1'b0;
    key_in    = 4'h0;
    key_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_row_out", 32'(row_out), 32'hF);
    chk("rst_pressed", 32'(pressed), 32'd0);
    chk("rst_key_active", 32'(key_active), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_key_ready", 32'(key_ready), 32'd1);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Idle sweep: no key queued, rows stay released.
    repeat (8) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_key_ready", 32'(key_ready), 32'd1);
    chk("idle_fifo_count", 32'(fifo_count), 32'd0);

    // Single key 5 with column 2 held low, then column 3 mid-press.
    col_fixed = 4'b1011;
    col_mode  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_key(4'h5, 4'b1011, 4'b1011, 0);
    chk("push_count", 32'(fifo_count), 32'd1);
    chk("push_pressed_early", 32'(pressed), 32'd0);
    @(posedge clk);
    #1;
    chk("pop_pressed", 32'(pressed), 32'd1);
    chk("pop_count", 32'(fifo_count), 32'd0);
    chk("pop_busy", 32'(busy), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    col_fixed = 4'b0111;
    wait_idle(100);

    // Back-to-back keys under a continuous column sweep.
    col_mode = 1'b1;
    expect_key(4'h1, 4'b0111, 4'b0111, 0);
    expect_key(4'h2, 4'b1011, 4'b0111, 13);
    expect_key(4'hA, 4'b1110, 4'b0111, 13);
    expect_key(4'hD, 4'b1110, 4'b1110, 13);
    wait_idle(200);

    // Fill the FIFO behind a running press, then hold a push against the full FIFO.
    expect_key(4'h3, 4'b1101, 4'b0111, 0);
    expect_key(4'h6, 4'b1101, 4'b1011, 13);
    expect_key(4'h7, 4'b0111, 4'b1101, 13);
    expect_key(4'h8, 4'b1011, 4'b1101, 13);
    expect_key(4'h9, 4'b1101, 4'b1101, 13);
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_key_ready", 32'(key_ready), 32'd0);
    key_in    = 4'hF;
    key_valid = 1'b1;
    waited    = 0;
    while (waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
      if (fifo_count != 3'd4) break;
    end
    key_valid = 1'b0;
    chk("full_pop_edge", 32'(waited), 32'd10);
    chk("full_pop_count", 32'(fifo_count), 32'd3);
    chk("after_pop_key_ready", 32'(key_ready), 32'd1);
    wait_idle(200);

    // Reset in the middle of a press with two keys still queued.
    mon_en = 1'b0;
    push(4'hB);
    push(4'hC);
    push(4'hE);
    chk("pre_rst_count", 32'(fifo_count), 32'd2);
    chk("pre_rst_pressed", 32'(pressed), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_row_out", 32'(row_out), 32'hF);
    chk("midrst_pressed", 32'(pressed), 32'd0);
    chk("midrst_fifo_count", 32'(fifo_count), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_key_ready", 32'(key_ready), 32'd1);
    reset_n   = 1'b1;
    saw_press = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (pressed || row_out != 4'hF) saw_press = 1'b1;
    end
    chk("post_rst_no_press", 32'(saw_press), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
